// File: rtl/pp_dot_accumulator.sv
// Sequential dot-product accumulator: reduces per-multiplier partial products,
// subtracts a per-beat correction and accumulates LEN beats into one signed result.
module pp_dot_accumulator #(
  parameter int unsigned NUM_MUL    = 4,
  parameter int unsigned PP_PER_MUL = 3,
  parameter int unsigned PP_SIZE    = 18,
  parameter int unsigned ACC_SIZE   = 32,
  parameter int unsigned LEN_W      = 8,
  localparam int unsigned NUM_PP    = NUM_MUL * PP_PER_MUL
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic                busy_o,
  input  logic [PP_SIZE-1:0]  pp_i [NUM_PP],
  input  logic [ACC_SIZE-1:0] corr_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [ACC_SIZE-1:0] res_o,
  output logic                ovf_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned EXT_W = ACC_SIZE - PP_SIZE;

  logic [1:0]          state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                pv_q, pv_d;
  logic [ACC_SIZE-1:0] beat_q, beat_d;
  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                busy_d, in_ready_d, out_valid_d, ovf_out_d;
  logic [ACC_SIZE-1:0] res_d;

  logic [PP_SIZE-1:0]  prod_c [NUM_MUL];
  logic [ACC_SIZE-1:0] beat_c;
  logic [ACC_SIZE-1:0] sum_c;
  logic                add_ovf_c;
  logic                accept_c;

  // Per-multiplier reduction wraps in PP_SIZE, then sign-extends into the beat sum.
  always_comb begin
    beat_c = '0;
    for (int m = 0; m < NUM_MUL; m++) begin
      prod_c[m] = '0;
      for (int k = 0; k < PP_PER_MUL; k++) begin
        prod_c[m] = prod_c[m] + pp_i[m*PP_PER_MUL + k];
      end
      beat_c = beat_c + {{EXT_W{prod_c[m][PP_SIZE-1]}}, prod_c[m]};
    end
    beat_c = beat_c - corr_i;
  end

  assign accept_c  = in_valid_i && in_ready_o;
  assign sum_c     = acc_q + beat_q;
  assign add_ovf_c = (acc_q[ACC_SIZE-1] == beat_q[ACC_SIZE-1]) &&
                     (sum_c[ACC_SIZE-1] != acc_q[ACC_SIZE-1]);

  // Next-state and next-output logic; the pipeline always drains on its own.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pv_d        = accept_c;
    beat_d      = accept_c ? beat_c : beat_q;
    acc_d       = pv_q ? sum_c : acc_q;
    ovf_d       = ovf_q | (pv_q & add_ovf_c);
    res_d       = res_o;
    ovf_out_d   = ovf_o;
    out_valid_d = out_valid_o;
    in_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d     = '0;
          ovf_d     = 1'b0;
          pv_d      = 1'b0;
          ovf_out_d = 1'b0;
          if (len_i != '0) begin
            cnt_d      = len_i;
            in_ready_d = 1'b1;
            state_d    = ACC;
          end else begin
            res_d       = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      ACC: begin
        if (accept_c) begin
          cnt_d = cnt_q - LEN_W'(1);
        end
        in_ready_d = (cnt_d != '0);
        // cnt reaching zero means the last beat is in stage 1 and lands in acc this edge.
        if (cnt_q == '0) begin
          in_ready_d  = 1'b0;
          res_d       = acc_d;
          ovf_out_d   = ovf_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pv_q        <= 1'b0;
      beat_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      busy_o      <= 1'b0;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      res_o       <= '0;
      ovf_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pv_q        <= pv_d;
      beat_q      <= beat_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      busy_o      <= busy_d;
      in_ready_o  <= in_ready_d;
      out_valid_o <= out_valid_d;
      res_o       <= res_d;
      ovf_o       <= ovf_out_d;
    end
  end

endmodule

// File: tb/tb_pp_dot_accumulator.sv
// Scoreboard bench for pp_dot_accumulator: directed jobs push expected results,
// a monitor pops and compares on every output handshake.
module tb_pp_dot_accumulator;

  localparam int unsigned NUM_MUL    = 4;
  localparam int unsigned PP_PER_MUL = 3;
  localparam int unsigned PP_SIZE    = 18;
  localparam int unsigned ACC_SIZE   = 32;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned NUM_PP     = NUM_MUL * PP_PER_MUL;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                start_i;
  logic [LEN_W-1:0]    len_i;
  logic                busy_o;
  logic [PP_SIZE-1:0]  pp_i [NUM_PP];
  logic [ACC_SIZE-1:0] corr_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [ACC_SIZE-1:0] res_o;
  logic                ovf_o;
  logic                out_valid_o;
  logic                out_ready_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ACC_SIZE:0] exp_q [$];

  pp_dot_accumulator #(
    .NUM_MUL(NUM_MUL), .PP_PER_MUL(PP_PER_MUL), .PP_SIZE(PP_SIZE),
    .ACC_SIZE(ACC_SIZE), .LEN_W(LEN_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .pp_i(pp_i), .corr_i(corr_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .res_o(res_o), .ovf_o(ovf_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_beat();
    for (int i = 0; i < NUM_PP; i++) pp_i[i] = '0;
    corr_i = '0;
  endtask

  // mult0 {5,0,0}, mult1 {-1,0,0}, mult2 wraps to 3, mult3 zero, corr 2 -> beat 5
  task automatic std_beat();
    clr_beat();
    pp_i[0] = 18'd5;
    pp_i[3] = 18'h3FFFF;
    pp_i[6] = 18'h20000;
    pp_i[7] = 18'h20000;
    pp_i[8] = 18'd3;
    corr_i  = 32'd2;
  endtask

  task automatic start_job(input logic [LEN_W-1:0] l);
    start_i = 1'b1;
    len_i   = l;
    tick();
    start_i = 1'b0;
    len_i   = '0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid_o && n < 30) begin tick(); n++; end
    chk("wait_valid_timeout", 32'(out_valid_o), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 30) begin tick(); n++; end
    chk("wait_idle_timeout", 32'(busy_o), 32'd0);
  endtask

  // Output monitor: every handshake must match the oldest expected result.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got res=%h ovf=%b, expected no result", res_o, ovf_o);
      end else begin
        logic [ACC_SIZE:0] e;
        e = exp_q.pop_front();
        chk("sb_res", res_o, e[ACC_SIZE-1:0]);
        chk("sb_ovf", 32'(ovf_o), 32'(e[ACC_SIZE]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pat;
    rst_ni = 1'b0; start_i = 1'b0; len_i = '0;
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    clr_beat();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_res", res_o, 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // Single beat, latency
    start_job(8'd1);
    chk("t1_in_ready", 32'(in_ready_o), 32'd1);
    std_beat();
    in_valid_i = 1'b1;
    exp_q.push_back({1'b0, 32'd5});
    tick();
    in_valid_i = 1'b0;
    clr_beat();
    chk("t1_valid_plus1", 32'(out_valid_o), 32'd0);
    tick();
    chk("t1_valid_plus2", 32'(out_valid_o), 32'd1);
    wait_idle();

    // Three beats with bubbles, extra valid after count exhausted
    start_job(8'd3);
    std_beat();
    exp_q.push_back({1'b0, 32'd15});
    pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      in_valid_i = pat[i];
      tick();
    end
    chk("t2_in_ready_after_last", 32'(in_ready_o), 32'd0);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    clr_beat();
    wait_idle();

    // Zero length
    start_i = 1'b1;
    len_i   = 8'd0;
    exp_q.push_back({1'b0, 32'd0});
    tick();
    start_i = 1'b0;
    chk("t3_valid", 32'(out_valid_o), 32'd1);
    chk("t3_in_ready", 32'(in_ready_o), 32'd0);
    chk("t3_res", res_o, 32'd0);
    wait_idle();

    // Backpressure, start during DONE and during the DONE->IDLE cycle
    out_ready_i = 1'b0;
    start_job(8'd1);
    std_beat();
    in_valid_i = 1'b1;
    exp_q.push_back({1'b0, 32'd5});
    tick();
    in_valid_i = 1'b0;
    clr_beat();
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      chk("t4_hold_valid", 32'(out_valid_o), 32'd1);
      chk("t4_hold_res", res_o, 32'd5);
      start_i = (i == 1);
      len_i   = 8'd7;
      tick();
    end
    start_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    len_i   = '0;
    chk("t4_idle_busy", 32'(busy_o), 32'd0);
    chk("t4_valid_drop", 32'(out_valid_o), 32'd0);
    tick();
    chk("t4_start_ignored", 32'(busy_o), 32'd0);

    // Signed overflow then cleared by the next job
    start_job(8'd2);
    clr_beat();
    corr_i = 32'hC000_0000;
    in_valid_i = 1'b1;
    exp_q.push_back({1'b1, 32'h8000_0000});
    tick();
    tick();
    in_valid_i = 1'b0;
    chk("t5_in_ready", 32'(in_ready_o), 32'd0);
    wait_idle();
    start_job(8'd1);
    chk("t5_ovf_cleared", 32'(ovf_o), 32'd0);
    std_beat();
    in_valid_i = 1'b1;
    exp_q.push_back({1'b0, 32'd5});
    tick();
    in_valid_i = 1'b0;
    wait_idle();

    // Asynchronous reset with 2 of 5 beats done
    start_job(8'd5);
    std_beat();
    in_valid_i = 1'b1;
    tick();
    tick();
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_in_ready", 32'(in_ready_o), 32'd0);
    chk("t6_out_valid", 32'(out_valid_o), 32'd0);
    chk("t6_res", res_o, 32'd0);
    chk("t6_ovf", 32'(ovf_o), 32'd0);
    #3 rst_ni = 1'b1;
    tick();
    start_job(8'd1);
    in_valid_i = 1'b1;
    exp_q.push_back({1'b0, 32'd5});
    tick();
    in_valid_i = 1'b0;
    clr_beat();
    wait_idle();

    repeat (2) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
